load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core datapath and the word-organised data memory. The core is the initiator; this block is the responder toward the core and the initiator toward the memory.
- Accepts one load/store request at a time over a valid/ready handshake and issues word-wide memory accesses.
- Performs RV32I byte/half/word lane selection, sign/zero extension on loads, and read-modify-write for sub-word stores (the memory has no byte enables).
- Returns one response per request, flagging misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 6: memory word-address width; byte space is 2^(ADDR_W+2) = 256 bytes.
- MEM_LAT, 1: cycles from the mem_read strobe until mem_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal funct3, or out-of-range.
- mem_addr  out  ADDR_W  word address.
- mem_read  out  1  one-cycle read strobe.
- mem_write  out  1  one-cycle write strobe.
- mem_wdata  out  32  write data (merged word).
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_read.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; FSM=IDLE; latches and counter cleared.
- All outputs come from registered state only; there is no combinational path from req_* to mem_* or resp_*.
- Accept occurs when req_valid && req_ready. req_ready=1 only in IDLE. On accept, addr, funct3, write and wdata are latched.
- FSM states: IDLE, RD, WAIT, WR, RESP.
  - IDLE -> RESP when the request is an error.
  - IDLE -> WR for SW.
  - IDLE -> RD for any load, SB or SH.
  - RD: mem_read=1 for exactly one cycle; mem_addr = addr[ADDR_W+1:2]; load counter with MEM_LAT; -> WAIT.
  - WAIT: decrement counter. When counter==1, capture mem_rdata this cycle; next state is RESP for loads, WR for stores.
  - WR: mem_write=1 for exactly one cycle. mem_wdata is req_wdata for SW, or the captured word with the target lane(s) replaced; -> RESP.
  - RESP: resp_valid=1 for exactly one cycle (no backpressure); -> IDLE.
- Latency from the accept cycle to resp_valid:
  - error: 1 cycle
  - SW: 2 cycles
  - load: 2+MEM_LAT cycles
  - SB/SH: 3+MEM_LAT cycles
  - Back-to-back: a new request can be accepted the cycle after RESP.
- Load funct3 decoding:
  - 000 LB: sign-extend the byte at addr[1:0].
  - 001 LH: sign-extend the half at addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Other values: error.
- Store funct3 decoding: 000 SB, 001 SH, 010 SW; other values: error.
- Byte order is little-endian: byte lane n = bits [8n+7:8n].
- Errors:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:ADDR_W+2]!=0;
  - illegal funct3.
  - On error, resp_err=1, resp_rdata=0, and no mem strobe is issued.
- resp_rdata is 0 on store responses. resp_err=0 on non-error responses.
- Reset mid-operation: next edge -> IDLE; strobes drop; no response is issued. A sub-word store reset before WR leaves memory unmodified.
- req_* inputs are ignored outside IDLE; no queuing.

Decomposition:
- Shared package risc_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - LSU state encoding (3-bit localparams);
  - an error-cause-free 1-bit error convention.
- One sub-module, lsu_align (combinational):
  - load extraction/extension from (word, addr[1:0], funct3);
  - store merge from (old word, wdata, addr[1:0], funct3).
- The FSM stays in load_store_unit.

Test Plan:
- LW: mem word 5 = 0xDEADBEEF, req addr 0x14 -> mem_read at cycle 1 with mem_addr=5; resp_valid at cycle 3 (MEM_LAT=1), rdata=0xDEADBEEF, err=0.
- LB/LBU/LH/LHU on word 0x8081F27F at addr 0x20..0x23:
  - LB@0x23 -> 0xFFFFFF80
  - LBU@0x22 -> 0x00000081
  - LH@0x22 -> 0xFFFF8081
  - LHU@0x20 -> 0x0000F27F
- SB 0xAB to addr 0x09 with word 2 = 0x11223344 -> one mem_read, then mem_write with mem_wdata=0x1122AB44; resp at cycle 4; later LW@0x08 returns 0x1122AB44.
- Errors:
  - LW@0x06 -> resp_err=1 at cycle 1, no mem strobe;
  - SH@0x03 -> err;
  - funct3=011 -> err;
  - addr 0x100 -> err (out of range).
- Reset asserted while in WAIT of an SB -> IDLE next cycle, no mem_write, no resp_valid; memory word unchanged; next request accepted normally.
- MEM_LAT=3 and back-to-back requests held valid -> LW resp at cycle 5; req_ready low throughout; second request accepted the cycle after RESP.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state encoding, request error check.
// Pure definitions; no latency or flow control of its own.
package risc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LSU_IDLE = 3'd0;
  localparam logic [2:0] LSU_RD   = 3'd1;
  localparam logic [2:0] LSU_WAIT = 3'd2;
  localparam logic [2:0] LSU_WR   = 3'd3;
  localparam logic [2:0] LSU_RESP = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = LSU_IDLE,
    ST_RD   = LSU_RD,
    ST_WAIT = LSU_WAIT,
    ST_WR   = LSU_WR,
    ST_RESP = LSU_RESP
  } lsu_state_t;

  // A single error bit; the cause is deliberately not reported to the core.
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;

  function automatic logic lsu_req_err(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [31:0] addr,
                                       input int          addr_w);
    logic w_bad_f3;
    logic w_bad_align;
    logic w_bad_range;
    case (funct3)
      F3_B, F3_H, F3_W: w_bad_f3 = 1'b0;
      F3_BU, F3_HU:     w_bad_f3 = write;
      default:          w_bad_f3 = 1'b1;
    endcase
    w_bad_align = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                  ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    w_bad_range = (addr >> (addr_w + 2)) != 32'd0;
    return (w_bad_f3 || w_bad_align || w_bad_range) ? ERR_SET : ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: load extract/extend and sub-word store merge.
// Purely combinational, zero latency; no flow control.
module lsu_align
  import risc_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = '0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_W:    o_load = i_word;
      F3_BU:   o_load = {24'd0, w_byte};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = '0;
    endcase
  end

  // The memory has no byte enables, so sub-word stores rewrite the whole word.
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word memory, RMW for SB/SH.
// Latency err 1, SW 2, load 2+MEM_LAT, SB/SH 3+MEM_LAT; req_ready low while busy, no response backpressure.
module load_store_unit
  import risc_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 1
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  lsu_state_t        r_state;
  logic [3:0]        r_cnt;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_err;
  logic              w_is_sw;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merged;

  assign w_accept = req_valid && r_req_ready;
  assign w_err    = lsu_req_err(req_write, req_funct3, req_addr, ADDR_W);
  assign w_is_sw  = req_write && (req_funct3 == F3_W);

  // Fed straight from mem_rdata: the load result and merged word are both
  // registered in the same cycle the read data is valid.
  lsu_align u_align (
    .i_word   (mem_rdata),
    .i_wdata  (r_wdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_load   (w_load_data),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_off        <= '0;
      r_funct3     <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_off       <= req_addr[1:0];
            r_funct3    <= req_funct3;
            r_write     <= req_write;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= ERR_SET;
              r_resp_rdata <= '0;
            end else if (w_is_sw) begin
              r_state     <= ST_WR;
              r_mem_write <= 1'b1;
              r_mem_addr  <= req_addr[ADDR_W+1:2];
              r_mem_wdata <= req_wdata;
            end else begin
              r_state    <= ST_RD;
              r_mem_read <= 1'b1;
              r_mem_addr <= req_addr[ADDR_W+1:2];
            end
          end
        end
        ST_RD: begin
          r_cnt   <= LAT_INIT;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_write) begin
              r_state     <= ST_WR;
              r_mem_write <= 1'b1;
              r_mem_wdata <= w_merged;
            end else begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= ERR_NONE;
              r_resp_rdata <= w_load_data;
            end
          end
        end
        ST_WR: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= ERR_NONE;
          r_resp_rdata <= '0;
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: MEM_LAT=1 instance for vectors/random traffic, MEM_LAT=3 instance for back-to-back timing.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;

  // MEM_LAT=3 instance
  logic        b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [2:0]  b_req_funct3 = '0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_read, b_mem_write;
  logic [31:0] b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic [5:0]  b_mem_addr;

  load_store_unit #(.ADDR_W(6), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  load_store_unit #(.ADDR_W(6), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_addr(b_mem_addr), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  // Memory models: read data is only valid exactly MEM_LAT cycles after the strobe.
  logic        pl_we = 1'b0;
  logic        pl_sel = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  logic [31:0] mem [64];
  logic        rd_v;
  logic [5:0]  rd_a;
  always @(posedge clk) begin
    rd_v <= rst ? 1'b0 : mem_read;
    rd_a <= mem_addr;
    if (pl_we && !pl_sel) mem[pl_a] <= pl_d;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = rd_v ? mem[rd_a] : 32'hBADC0DE5;

  logic [31:0] b_mem [64];
  logic [2:0]  b_v;
  logic [5:0]  b_a [3];
  always @(posedge clk) begin
    b_v    <= rst ? 3'b000 : {b_v[1:0], b_mem_read};
    b_a[0] <= b_mem_addr;
    b_a[1] <= b_a[0];
    b_a[2] <= b_a[1];
    if (pl_we && pl_sel) b_mem[pl_a] <= pl_d;
    else if (b_mem_write) b_mem[b_mem_addr] <= b_mem_wdata;
  end
  assign b_mem_rdata = b_v[2] ? b_mem[b_a[2]] : 32'hBADC0DE5;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference rules, stated directly in bytes and masks.
  function automatic logic m_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic ok_f3;
    int   sz;
    ok_f3 = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz    = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    return !ok_f3 || ((a % sz) != 0) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a, input logic [2:0] f3);
    int unsigned nb, v, sh;
    if (f3 == 3'd2) return word;
    nb = f3[0] ? 2 : 1;
    sh = 8 * (a % 4);
    v  = (word >> sh) & ((32'd1 << (8 * nb)) - 1);
    if (!f3[2] && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] f3);
    int unsigned sh;
    logic [31:0] mask;
    if (f3 == 3'd2) return wd;
    sh   = 8 * (a % 4);
    mask = ((f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic preload(input logic sel, input logic [5:0] idx, input logic [31:0] d);
    pl_we = 1'b1; pl_sel = sel; pl_a = idx; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
    if (!sel) ref_mem[idx] = d;
  endtask

  // One request on the MEM_LAT=1 instance; cycle k counts from the accept edge.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr, output logic [31:0] wdat,
                        output logic [5:0] maddr, output int rcyc);
    lat = -1; rd = 'x; er = 'x; nrd = 0; nwr = 0; wdat = '0; maddr = '0; rcyc = -1;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_read)  begin nrd++; maddr = mem_addr; rcyc = k; end
      if (mem_write) begin nwr++; maddr = mem_addr; wdat = mem_wdata; end
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; break; end
      @(negedge clk);
    end
    @(negedge clk);
    chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic run_check(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] e_rd, input logic e_er,
                           input int e_lat, input int e_nrd, input int e_nwr, input logic [31:0] e_wdat);
    int lat, nrd, nwr, rcyc;
    logic [31:0] rd, wdat;
    logic er;
    logic [5:0] maddr;
    do_req(w, f3, a, wd, lat, rd, er, nrd, nwr, wdat, maddr, rcyc);
    chk({tag, " lat"},   lat, e_lat);
    chk({tag, " rdata"}, rd, e_rd);
    chk({tag, " err"},   {31'd0, er}, {31'd0, e_er});
    chk({tag, " reads"}, nrd, e_nrd);
    chk({tag, " writes"}, nwr, e_nwr);
    if (e_nwr > 0) chk({tag, " wdata"}, wdat, e_wdat);
    if (e_nrd + e_nwr > 0) chk({tag, " maddr"}, {26'd0, maddr}, a >> 2);
    if (e_nrd > 0) chk({tag, " rd_cycle"}, rcyc, 1);
    if (w && !e_er) ref_mem[a[7:2]] = e_wdat;
  endtask

  typedef struct {
    logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
    logic [31:0] rd; logic er; int lat; int nrd; int nwr; logic [31:0] wdat;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic er, input int lat, input int nrd,
                              input int nwr, input logic [31:0] wdat);
    vec_t v;
    v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.er = er;
    v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.wdat = wdat;
    return v;
  endfunction

  vec_t vt [20];

  initial begin
    int cnt_w, cnt_r, nmis, rdy_hi, n, r1, r2;
    logic rdy6;
    logic [31:0] d1, d2;

    vt[0]  = mk(0, 3'd2, 32'h14,  0, 32'hDEADBEEF, 0, 3, 1, 0, 0);
    vt[1]  = mk(0, 3'd0, 32'h23,  0, 32'hFFFFFF80, 0, 3, 1, 0, 0);
    vt[2]  = mk(0, 3'd4, 32'h22,  0, 32'h00000081, 0, 3, 1, 0, 0);
    vt[3]  = mk(0, 3'd1, 32'h22,  0, 32'hFFFF8081, 0, 3, 1, 0, 0);
    vt[4]  = mk(0, 3'd5, 32'h20,  0, 32'h0000F27F, 0, 3, 1, 0, 0);
    vt[5]  = mk(1, 3'd0, 32'h09,  32'h000000AB, 0, 0, 4, 1, 1, 32'h1122AB44);
    vt[6]  = mk(0, 3'd2, 32'h08,  0, 32'h1122AB44, 0, 3, 1, 0, 0);
    vt[7]  = mk(0, 3'd2, 32'h06,  0, 0, 1, 1, 0, 0, 0);
    vt[8]  = mk(1, 3'd1, 32'h03,  32'h5555, 0, 1, 1, 0, 0, 0);
    vt[9]  = mk(0, 3'd3, 32'h00,  0, 0, 1, 1, 0, 0, 0);
    vt[10] = mk(0, 3'd2, 32'h100, 0, 0, 1, 1, 0, 0, 0);
    vt[11] = mk(1, 3'd2, 32'h30,  32'hCAFEF00D, 0, 0, 2, 0, 1, 32'hCAFEF00D);
    vt[12] = mk(0, 3'd2, 32'h30,  0, 32'hCAFEF00D, 0, 3, 1, 0, 0);
    vt[13] = mk(0, 3'd1, 32'h21,  0, 0, 1, 1, 0, 0, 0);
    vt[14] = mk(1, 3'd4, 32'h10,  32'h77, 0, 1, 1, 0, 0, 0);
    vt[15] = mk(1, 3'd1, 32'h32,  32'h12345678, 0, 0, 4, 1, 1, 32'h5678F00D);
    vt[16] = mk(0, 3'd0, 32'h33,  0, 32'h00000056, 0, 3, 1, 0, 0);
    vt[17] = mk(0, 3'd5, 32'hFE,  0, 32'h00009ABC, 0, 3, 1, 0, 0);
    vt[18] = mk(0, 3'd0, 32'hFF,  0, 32'hFFFFFF9A, 0, 3, 1, 0, 0);
    vt[19] = mk(0, 3'd0, 32'h80000000, 0, 0, 1, 1, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(1'b0, 6'(i), (32'h01000193 * i) ^ 32'hA5A5A5A5);
    preload(1'b0, 6'd5,  32'hDEADBEEF);
    preload(1'b0, 6'd8,  32'h8081F27F);
    preload(1'b0, 6'd2,  32'h11223344);
    preload(1'b0, 6'd63, 32'h9ABCDEF0);
    preload(1'b1, 6'd7,  32'h0BADF00D);
    preload(1'b1, 6'd1,  32'h13579BDF);

    // Reset values
    chk("rst req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err",   {31'd0, resp_err}, 32'd0);
    chk("rst strobes",    {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst mem_addr",   {26'd0, mem_addr}, 32'd0);
    chk("rst mem_wdata",  mem_wdata, 32'd0);
    chk("rst b_req_ready", {31'd0, b_req_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++)
      run_check($sformatf("vec%0d", i), vt[i].w, vt[i].f3, vt[i].a, vt[i].wd, vt[i].rd, vt[i].er,
                vt[i].lat, vt[i].nrd, vt[i].nwr, vt[i].wdat);

    // SB interrupted by reset while waiting for read data
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h29; req_wdata = 32'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid rd", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid quiet", {29'd0, mem_read, mem_write, resp_valid}, 32'd0);
    rst = 1'b0;
    cnt_w = 0; cnt_r = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_write) cnt_w++;
      if (resp_valid) cnt_r++;
    end
    chk("rstmid no write", cnt_w, 0);
    chk("rstmid no resp",  cnt_r, 0);
    chk("rstmid mem10",    mem[10], ref_mem[10]);
    run_check("after_rst", 1'b0, 3'd2, 32'h28, 0, ref_mem[10], 1'b0, 3, 1, 0, 0);

    // Randomised traffic against the reference rules
    for (int t = 0; t < 150; t++) begin
      logic w, er;
      logic [2:0] f3;
      logic [31:0] a, wd, e_rd, e_wdat;
      int e_lat, e_nrd, e_nwr;
      w  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; 4: f3 = 3'd5;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a < 32'd256) a = a | 32'h100;
      end else begin
        a = $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      end
      wd = $urandom;
      er = m_err(w, f3, a);
      e_rd = 0; e_wdat = 0; e_nrd = 0; e_nwr = 0; e_lat = 1;
      if (!er && !w) begin
        e_lat = 3; e_nrd = 1; e_rd = m_load(ref_mem[a[7:2]], a, f3);
      end else if (!er && f3 == 3'd2) begin
        e_lat = 2; e_nwr = 1; e_wdat = wd;
      end else if (!er) begin
        e_lat = 4; e_nrd = 1; e_nwr = 1; e_wdat = m_merge(ref_mem[a[7:2]], wd, a, f3);
      end
      run_check($sformatf("rnd%0d", t), w, f3, a, wd, e_rd, er, e_lat, e_nrd, e_nwr, e_wdat);
    end

    nmis = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_final mismatches", nmis, 0);

    // MEM_LAT=3: request held valid across two back-to-back loads
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_funct3 = 3'd2; b_req_addr = 32'h1C;
    rdy_hi = 0; n = 0; r1 = -1; r2 = -1; d1 = '0; d2 = '0; rdy6 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) b_req_addr = 32'h04;
      if (k <= 5 && b_req_ready) rdy_hi++;
      if (k == 6) rdy6 = b_req_ready;
      if (k == 7) b_req_valid = 1'b0;
      if (b_resp_valid) begin
        if (n == 0) begin r1 = k; d1 = b_resp_rdata; end
        else if (n == 1) begin r2 = k; d2 = b_resp_rdata; end
        n++;
      end
    end
    chk("lat3 busy ready", rdy_hi, 0);
    chk("lat3 resp1 cycle", r1, 5);
    chk("lat3 resp1 data", d1, 32'h0BADF00D);
    chk("lat3 ready after resp", {31'd0, rdy6}, 32'd1);
    chk("lat3 resp2 cycle", r2, 11);
    chk("lat3 resp2 data", d2, 32'h13579BDF);
    chk("lat3 resp count", n, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
